gx4000_cpr_loader: RTL

- Upstream stage of the GX4000 block: parses a CPR cartridge image (RIFF container, "AMS!" form, "cbNN" bank chunks) arriving on the MiSTer ioctl download stream.
- Emits flat cartridge writes (cart_download/cart_addr/cart_data/cart_wr) consumed by the GX4000 cartridge, memory and ASIC paths.
- Bank NN maps to cart_addr = NN*BANK_BYTES + offset.
- Applies back-pressure to the HPS through ioctl_wait and reports load status.

---
 rtl/gx4000_pkg.sv | 47 ++++
 rtl/gx4000_cpr_wrbuf.sv | 44 ++++
 rtl/gx4000_cpr_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gx4000_pkg.sv
// Shared types and constants for the GX4000 CPR cartridge image loader.
// FOURCC constants hold the first stream byte in the most significant byte.
package gx4000_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RIFF_ID,
    ST_RIFF_LEN,
    ST_FORM_ID,
    ST_CHK_ID,
    ST_CHK_LEN,
    ST_CHK_DATA,
    ST_CHK_SKIP,
    ST_DONE,
    ST_ERROR
  } cpr_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RIFF  = 3'd1;
  localparam logic [2:0] ERR_FORM  = 3'd2;
  localparam logic [2:0] ERR_CHUNK = 3'd3;
  localparam logic [2:0] ERR_ADDR  = 3'd4;
  localparam logic [2:0] ERR_TRUNC = 3'd5;

  localparam logic [31:0] FOURCC_RIFF = "RIFF";
  localparam logic [31:0] FOURCC_AMS  = "AMS!";
  localparam logic [15:0] FOURCC_CB   = "cb";

  function automatic logic [7:0] fourcc_byte(input logic [31:0] f, input logic [1:0] idx);
    case (idx)
      2'd0:    return f[31:24];
      2'd1:    return f[23:16];
      2'd2:    return f[15:8];
      default: return f[7:0];
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_parsing(input cpr_state_t s);
    return s inside {ST_RIFF_ID, ST_RIFF_LEN, ST_FORM_ID, ST_CHK_ID,
                     ST_CHK_LEN, ST_CHK_DATA, ST_CHK_SKIP};
  endfunction

endpackage

// File: rtl/gx4000_cpr_wrbuf.sv
// Single-entry cartridge write buffer; drains on the first cycle downstream is not busy.
// Flush drops a pending entry so nothing reaches the cartridge after a parse error.
module gx4000_cpr_wrbuf #(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        data_i,
  input  logic              cart_busy_i,
  output logic              cart_wr_o,
  output logic [ADDR_W-1:0] cart_addr_o,
  output logic [7:0]        cart_data_o,
  output logic              full_o
);

  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (full_q && !cart_busy_i) begin
      full_q <= 1'b0;
    end
  end

  assign cart_wr_o   = full_q & ~cart_busy_i;
  assign cart_addr_o = addr_q;
  assign cart_data_o = data_q;
  assign full_o      = full_q;

endmodule

// File: rtl/gx4000_cpr_loader.sv
// CPR (RIFF "AMS!" / "cbNN") image parser on the ioctl download stream.
// Produces flat cartridge writes through a one-entry buffer and reports load status.
module gx4000_cpr_loader
  import gx4000_pkg::*;
#(
  parameter int MAX_BANKS  = 32,
  parameter int BANK_BYTES = 16384,
  parameter int ADDR_W     = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cart_busy,
  output logic              cart_download,
  output logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_data,
  output logic              cart_wr,
  output logic [31:0]       bank_mask,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        error_code
);

  localparam int BANK_W = (MAX_BANKS > 1) ? $clog2(MAX_BANKS) : 1;
  localparam int OFF_W  = $clog2(BANK_BYTES) + 1;

  cpr_state_t        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       field_q, field_d;
  logic [32:0]       rem_q, rem_d;
  logic              pad_q, pad_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              is_cb_q, is_cb_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic [31:0]       mask_q, mask_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [2:0]        code_q, code_d;
  logic              cdl_q, cdl_d;
  logic              dl_q;

  logic              dl_rise, dl_fall;
  cpr_state_t        st_cur;
  logic [1:0]        idx_cur;
  logic [ADDR_W-1:0] exp_cur;
  logic [2:0]        byte_err;
  logic [31:0]       len_now;
  logic [7:0]        d_hi, d_lo;
  logic [6:0]        bank_num;
  logic              bank_ok;
  logic              buf_load, buf_flush, buf_full;
  logic [ADDR_W-1:0] wr_addr;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign len_now  = {ioctl_dout, field_q[31:8]};
  assign d_hi     = field_q[7:0] - 8'h30;
  assign d_lo     = ioctl_dout - 8'h30;
  assign bank_num = 7'(d_hi) * 7'd10 + 7'(d_lo);
  assign bank_ok  = is_digit(field_q[7:0]) && is_digit(ioctl_dout) && (32'(bank_num) < MAX_BANKS);
  assign wr_addr  = ADDR_W'(bank_q) * ADDR_W'(BANK_BYTES) + ADDR_W'(off_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    field_d   = field_q;
    rem_d     = rem_q;
    pad_d     = pad_q;
    off_d     = off_q;
    bank_d    = bank_q;
    is_cb_d   = is_cb_q;
    exp_d     = exp_q;
    mask_d    = mask_q;
    done_d    = done_q;
    error_d   = error_q;
    code_d    = code_q;
    cdl_d     = cdl_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    byte_err  = ERR_NONE;
    st_cur    = dl_rise ? ST_RIFF_ID : state_q;
    idx_cur   = dl_rise ? 2'd0 : idx_q;
    exp_cur   = dl_rise ? '0 : exp_q;

    if (dl_rise) begin
      state_d = ST_RIFF_ID;
      idx_d   = 2'd0;
      exp_d   = '0;
      mask_d  = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
      code_d  = ERR_NONE;
      cdl_d   = 1'b0;
    end

    if (ioctl_wr && is_parsing(st_cur)) begin
      // A byte offered while the buffer is full breaks the wait handshake.
      if (buf_full || (ioctl_addr != exp_cur)) begin
        byte_err = ERR_ADDR;
      end else begin
        exp_d = exp_cur + ADDR_W'(1);
        cdl_d = 1'b1;
        unique case (st_cur)
          ST_RIFF_ID: begin
            if (ioctl_dout != fourcc_byte(FOURCC_RIFF, idx_cur)) byte_err = ERR_RIFF;
            else begin
              idx_d = idx_cur + 2'd1;
              if (idx_cur == 2'd3) state_d = ST_RIFF_LEN;
            end
          end
          ST_RIFF_LEN: begin
            field_d = len_now;
            idx_d   = idx_cur + 2'd1;
            if (idx_cur == 2'd3) state_d = ST_FORM_ID;
          end
          ST_FORM_ID: begin
            if (ioctl_dout != fourcc_byte(FOURCC_AMS, idx_cur)) byte_err = ERR_FORM;
            else begin
              idx_d = idx_cur + 2'd1;
              if (idx_cur == 2'd3) state_d = ST_CHK_ID;
            end
          end
          ST_CHK_ID: begin
            field_d = {field_q[23:0], ioctl_dout};
            idx_d   = idx_cur + 2'd1;
            if (idx_cur == 2'd3) begin
              if (field_q[23:8] == FOURCC_CB) begin
                if (bank_ok) begin
                  is_cb_d = 1'b1;
                  bank_d  = BANK_W'(bank_num);
                  state_d = ST_CHK_LEN;
                end else begin
                  byte_err = ERR_CHUNK;
                end
              end else begin
                is_cb_d = 1'b0;
                state_d = ST_CHK_LEN;
              end
            end
          end
          ST_CHK_LEN: begin
            field_d = len_now;
            idx_d   = idx_cur + 2'd1;
            if (idx_cur == 2'd3) begin
              rem_d = {1'b0, len_now} + 33'(len_now[0]);
              pad_d = len_now[0];
              off_d = '0;
              if (len_now == 32'd0) state_d = ST_CHK_ID;
              else                  state_d = is_cb_q ? ST_CHK_DATA : ST_CHK_SKIP;
            end
          end
          ST_CHK_DATA: begin
            // Pad byte and anything past the bank size are consumed silently.
            if (!(pad_q && rem_q == 33'd1) && (32'(off_q) < BANK_BYTES)) begin
              buf_load       = 1'b1;
              mask_d[bank_q] = 1'b1;
              off_d          = off_q + OFF_W'(1);
            end
            rem_d = rem_q - 33'd1;
            if (rem_q == 33'd1) state_d = ST_CHK_ID;
          end
          ST_CHK_SKIP: begin
            rem_d = rem_q - 33'd1;
            if (rem_q == 33'd1) state_d = ST_CHK_ID;
          end
          default: ;
        endcase
      end
    end

    if (byte_err != ERR_NONE) begin
      state_d   = ST_ERROR;
      error_d   = 1'b1;
      code_d    = byte_err;
      cdl_d     = 1'b0;
      buf_flush = 1'b1;
    end

    // The fall is judged against the state reached after this cycle's byte.
    if (dl_fall) begin
      if (state_d == ST_CHK_ID && idx_d == 2'd0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        cdl_d   = 1'b0;
      end else if (is_parsing(state_d)) begin
        state_d = ST_ERROR;
        error_d = 1'b1;
        code_d  = ERR_TRUNC;
        cdl_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      field_q <= '0;
      rem_q   <= '0;
      pad_q   <= 1'b0;
      off_q   <= '0;
      bank_q  <= '0;
      is_cb_q <= 1'b0;
      exp_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      cdl_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      field_q <= field_d;
      rem_q   <= rem_d;
      pad_q   <= pad_d;
      off_q   <= off_d;
      bank_q  <= bank_d;
      is_cb_q <= is_cb_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      cdl_q   <= cdl_d;
      dl_q    <= ioctl_download;
    end
  end

  gx4000_cpr_wrbuf #(.ADDR_W(ADDR_W)) u_wrbuf (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load_i     (buf_load),
    .flush_i    (buf_flush),
    .addr_i     (wr_addr),
    .data_i     (ioctl_dout),
    .cart_busy_i(cart_busy),
    .cart_wr_o  (cart_wr),
    .cart_addr_o(cart_addr),
    .cart_data_o(cart_data),
    .full_o     (buf_full)
  );

  assign ioctl_wait    = buf_full & (state_q != ST_ERROR);
  assign cart_download = cdl_q;
  assign bank_mask     = mask_q;
  assign load_done     = done_q;
  assign load_error    = error_q;
  assign error_code    = code_q;

endmodule
